midi_tx: RTL

- MIDI transmitter. Converts one channel-voice event per handshake into the MIDI byte sequence, then serialises it onto a 31250-baud UART line (1 start bit, 8 data bits LSB first, 1 stop bit, idle high).
- Mirror of the synth's MIDI receive path. Uses the same 3-bit command code (status[6:4]) so the front panel/sequencer can echo or generate streams the synth parser accepts.

---
 rtl/midi_pkg.sv | 24 ++
 rtl/midi_uart_tx.sv | 64 ++++++
 rtl/midi_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: command codes, reset status byte, per-command byte
// count and the event FSM state encoding (also used by the receive parser).
package midi_pkg;
  localparam logic [2:0] CMD_NOTE_OFF   = 3'b000;
  localparam logic [2:0] CMD_NOTE_ON    = 3'b001;
  localparam logic [2:0] CMD_POLY_PRES  = 3'b010;
  localparam logic [2:0] CMD_CTRL_CHG   = 3'b011;
  localparam logic [2:0] CMD_PROG_CHG   = 3'b100;
  localparam logic [2:0] CMD_CHAN_PRES  = 3'b101;
  localparam logic [2:0] CMD_PITCH_BEND = 3'b110;
  localparam logic [2:0] CMD_SYS_RST    = 3'b111;

  localparam logic [7:0] STATUS_RESET = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_STATUS, ST_DATA1, ST_DATA2} ev_state_t;

  function automatic logic [1:0] nbytes(input logic [2:0] c);
    case (c)
      CMD_PROG_CHG, CMD_CHAN_PRES: nbytes = 2'd2;
      CMD_SYS_RST:                 nbytes = 2'd1;
      default:                     nbytes = 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/midi_uart_tx.sv
// 8N1 serialiser. Ready is raised in the last cycle of the stop bit so the
// next byte's start bit follows with no gap.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int BIT_DIV = 768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       line,
  output logic [7:0] cur_byte,
  output logic       strobe
);
  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

  logic          active;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          last;

  assign last  = active && (bit_cnt == 4'd9) && (div_cnt == DIV_LAST);
  assign ready = !active || last;
  // Idle shifts fill with ones, so bit 0 doubles as the idle-high line.
  assign line  = shreg[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      shreg    <= 10'h3FF;
      bit_cnt  <= 4'd0;
      div_cnt  <= '0;
      cur_byte <= 8'h00;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (load && ready) begin
        active   <= 1'b1;
        shreg    <= {1'b1, data, 1'b0};
        cur_byte <= data;
        strobe   <= 1'b1;
        bit_cnt  <= 4'd0;
        div_cnt  <= '0;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          shreg   <= {1'b1, shreg[9:1]};
          if (bit_cnt == 4'd9) begin
            active  <= 1'b0;
            bit_cnt <= 4'd0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/midi_tx.sv
// MIDI channel-voice transmitter: event FSM feeding midi_uart_tx.
// Define MIDI_TX_RUNNING_STATUS_EN to suppress repeated status bytes.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ  = 24000000,
  parameter int BAUD    = 31250,
  parameter int BIT_DIV = CLK_HZ / BAUD
) (
  input  logic       EXT_CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [3:0] channel,
  input  logic [6:0] data1,
  input  logic [6:0] data2,
  output logic       midi_tx_o,
  output logic [7:0] byte_o,
  output logic       byte_strobe,
  output logic       busy
);
  ev_state_t  state, next_state;
  logic [2:0] cmd_q;
  logic [6:0] d1_q, d2_q;
  logic       load, uart_ready, accept, skip_status;
  logic [7:0] load_byte, status;

  assign status    = {1'b1, cmd, channel};
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  assign skip_status = (cmd != CMD_SYS_RST) && (status == last_status);
  always_ff @(posedge EXT_CLK) begin
    if (RST)         last_status <= 8'h00;
    else if (accept) last_status <= (cmd == CMD_SYS_RST) ? 8'h00 : status;
  end
`else
  assign skip_status = 1'b0;
`endif

  always_ff @(posedge EXT_CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cmd_q <= 3'd0;
      d1_q  <= 7'd0;
      d2_q  <= 7'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        cmd_q <= cmd;
        d1_q  <= data1;
        d2_q  <= data2;
      end
    end
  end

  // The first byte is loaded straight from the inputs at acceptance so the
  // start bit appears on the very next cycle.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_byte  = 8'h00;
    case (state)
      ST_IDLE: if (cmd_valid) begin
        load = 1'b1;
        if (cmd == CMD_SYS_RST) begin
          load_byte  = STATUS_RESET;
          next_state = ST_STATUS;
        end else if (skip_status) begin
          load_byte  = {1'b0, data1};
          next_state = ST_DATA1;
        end else begin
          load_byte  = status;
          next_state = ST_STATUS;
        end
      end
      ST_STATUS: if (uart_ready) begin
        if (nbytes(cmd_q) == 2'd1) begin
          next_state = ST_IDLE;
        end else begin
          load       = 1'b1;
          load_byte  = {1'b0, d1_q};
          next_state = ST_DATA1;
        end
      end
      ST_DATA1: if (uart_ready) begin
        if (nbytes(cmd_q) == 2'd3) begin
          load       = 1'b1;
          load_byte  = {1'b0, d2_q};
          next_state = ST_DATA2;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_DATA2: if (uart_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  midi_uart_tx #(.BIT_DIV(BIT_DIV)) u_uart (
    .clk      (EXT_CLK),
    .rst      (RST),
    .load     (load),
    .data     (load_byte),
    .ready    (uart_ready),
    .line     (midi_tx_o),
    .cur_byte (byte_o),
    .strobe   (byte_strobe)
  );
endmodule
